// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler
// Shares one serial binary-to-BCD engine among CHANNELS binary counters.
// A channel is pending when its source differs from the snapshot taken at
// its last grant, or when a forced reconversion is outstanding. Pending
// channels are granted round-robin, one conversion at a time. Each result
// is captured into that channel's BCD register. An engine that never
// completes is aborted after a fixed budget and the channel is retried.
module bcd_conv_scheduler #(
  parameter int CHANNELS      = 3,
  parameter int BINARY_BITS   = 16,
  parameter int BCD_DIGITS    = 5,
  parameter int TIMEOUT_SLACK = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CHANNELS*BINARY_BITS-1:0]  bin_in,
  input  logic                             force_all,
  output logic [CHANNELS*4*BCD_DIGITS-1:0] bcd_out,
  output logic [CHANNELS-1:0]              bcd_valid,
  output logic                             conv_err,
  output logic                             cv_start,
  output logic [BINARY_BITS-1:0]           cv_bin,
  input  logic                             cv_busy,
  input  logic [4*BCD_DIGITS-1:0]          cv_bcd
);

  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RW        = 4 * BCD_DIGITS;
  localparam int TMO_LIMIT = BINARY_BITS + TIMEOUT_SLACK;
  localparam int TW        = $clog2(TMO_LIMIT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] CONVERT   = 2'd3;

  logic [1:0]                      state_q, state_d;
  logic [CW-1:0]                   sel_q, sel_d;
  logic [CW-1:0]                   last_grant_q, last_grant_d;
  logic [CHANNELS*BINARY_BITS-1:0] snap_q, snap_d;
  logic [CHANNELS-1:0]             force_pend_q, force_pend_d;
  logic [TW-1:0]                   tmo_q, tmo_d;
  logic [BINARY_BITS-1:0]          cv_bin_q, cv_bin_d;
  logic [CHANNELS*RW-1:0]          bcd_q, bcd_d;
  logic [CHANNELS-1:0]             captured_q, captured_d;
  logic [CHANNELS-1:0]             valid_q, valid_d;
  logic                            err_q, err_d;

  logic [CHANNELS-1:0]             pending;
  logic                            grant_found;
  logic [CW-1:0]                   grant_idx;
  logic                            tmo_hit;
  logic                            start_c;

  // A channel needs service if its source moved since its last grant or a
  // forced reconversion is outstanding.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default on entry, so
    // no path leaves it holding its old value (which would infer a latch).
    pending = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pending[c] = force_pend_q[c] |
                   (bin_in[c*BINARY_BITS +: BINARY_BITS] !=
                    snap_q[c*BINARY_BITS +: BINARY_BITS]);
    end
  end

  // Round-robin pick: first pending channel after the last grant, with wrap.
  always_comb begin
    logic [CW:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = {1'b0, last_grant_q} + (CW+1)'(i);
      if (cand >= (CW+1)'(CHANNELS)) cand = cand - (CW+1)'(CHANNELS);
      if (!grant_found && pending[cand[CW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[CW-1:0];
      end
    end
  end

  // The abort fires on the last budgeted cycle of an active conversion.
  assign tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TMO_LIMIT - 1));

  // Scheduler FSM: grant, start pulse, busy handshake, capture or abort.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    snap_d       = snap_q;
    force_pend_d = force_pend_q;
    tmo_d        = tmo_q;
    cv_bin_d     = cv_bin_q;
    bcd_d        = bcd_q;
    captured_d   = captured_q;
    err_d        = err_q;
    start_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          cv_bin_d     = bin_in[grant_idx*BINARY_BITS +: BINARY_BITS];
          snap_d[grant_idx*BINARY_BITS +: BINARY_BITS] =
            bin_in[grant_idx*BINARY_BITS +: BINARY_BITS];
          force_pend_d[grant_idx] = 1'b0;
          last_grant_d = grant_idx;
          sel_d        = grant_idx;
          tmo_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_hit) begin
          err_d               = 1'b1;
          force_pend_d[sel_q] = 1'b1;
          state_d             = IDLE;
        end else if (!cv_busy) begin
          // The start pulse is held back while a previous (possibly hung)
          // conversion still occupies the engine.
          start_c = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_hit) begin
          err_d               = 1'b1;
          force_pend_d[sel_q] = 1'b1;
          state_d             = IDLE;
        end else if (cv_busy) begin
          state_d = CONVERT;
        end
      end
      default: begin
        tmo_d = tmo_q + 1'b1;
        if (!cv_busy) begin
          bcd_d[sel_q*RW +: RW] = cv_bcd;
          captured_d[sel_q]     = 1'b1;
          state_d               = IDLE;
        end else if (tmo_hit) begin
          err_d               = 1'b1;
          force_pend_d[sel_q] = 1'b1;
          state_d             = IDLE;
        end
      end
    endcase

    // A forced reconversion overrides the clear applied at grant time.
    if (force_all) force_pend_d = '1;
  end

  // A result is valid once captured, not stale, and not being reconverted.
  always_comb begin
    valid_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      valid_d[c] = captured_q[c] & ~pending[c] &
                   ~((state_q != IDLE) && (sel_q == CW'(c)));
    end
  end

  // State registers; every channel is scheduled once after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_grant_q <= CW'(CHANNELS - 1);
      snap_q       <= '0;
      force_pend_q <= '1;
      tmo_q        <= '0;
      cv_bin_q     <= '0;
      bcd_q        <= '0;
      captured_q   <= '0;
      valid_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      snap_q       <= snap_d;
      force_pend_q <= force_pend_d;
      tmo_q        <= tmo_d;
      cv_bin_q     <= cv_bin_d;
      bcd_q        <= bcd_d;
      captured_q   <= captured_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign cv_start  = start_c;
  assign cv_bin    = cv_bin_q;
  assign bcd_out   = bcd_q;
  assign bcd_valid = valid_q;
  assign conv_err  = err_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Testbench for bcd_conv_scheduler: a behavioural engine that follows the
// busy contract (with an optional hang), plus a reference model that
// predicts grant order and BCD results from decimal arithmetic.
module tb_bcd_conv_scheduler;

  localparam int CH = 3;
  localparam int BB = 16;
  localparam int BD = 5;
  localparam int SL = 8;
  localparam int RW = 4 * BD;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*BB-1:0]  bin_in;
  logic              force_all;
  logic [CH*RW-1:0]  bcd_out;
  logic [CH-1:0]     bcd_valid;
  logic              conv_err;
  logic              cv_start;
  logic [BB-1:0]     cv_bin;
  logic              cv_busy;
  logic [RW-1:0]     cv_bcd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bcd_conv_scheduler #(
    .CHANNELS(CH), .BINARY_BITS(BB), .BCD_DIGITS(BD), .TIMEOUT_SLACK(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .force_all(force_all),
    .bcd_out(bcd_out), .bcd_valid(bcd_valid), .conv_err(conv_err),
    .cv_start(cv_start), .cv_bin(cv_bin), .cv_busy(cv_busy), .cv_bcd(cv_bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference conversion by repeated decimal division.
  function automatic logic [RW-1:0] to_bcd(input logic [BB-1:0] v);
    logic [RW-1:0] r;
    int x;
    r = '0;
    x = int'(v);
    for (int d = 0; d < BD; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Engine: busy for BB cycles starting the cycle after cv_start; in hang
  // mode busy never drops. The result bus carries junk while busy.
  logic          hang;
  int            eng_cnt;
  logic [BB-1:0] eng_op;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_busy <= 1'b0;
      cv_bcd  <= '0;
      eng_cnt <= 0;
      eng_op  <= '0;
    end else if (cv_start) begin
      eng_op  <= cv_bin;
      eng_cnt <= BB;
      cv_busy <= 1'b1;
      cv_bcd  <= '1;
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end else if (eng_cnt == 1 && !hang) begin
      eng_cnt <= 0;
      cv_busy <= 1'b0;
      cv_bcd  <= to_bcd(eng_op);
    end
  end

  // Start monitor: logs every operand issued and rejects starts into a busy engine.
  logic [BB-1:0] start_q[$];
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cv_start === 1'b1) begin
      start_q.push_back(cv_bin);
      checks++;
      if (cv_busy !== 1'b0) begin
        errors++;
        $display("FAIL start_while_busy: cv_busy=%b at cycle %0d, required 0", cv_busy, cyc);
      end
    end
  end

  // Reference model state.
  logic [BB-1:0] m_bin[CH];
  int            m_lg;

  task automatic set_ch(input int c, input logic [BB-1:0] v);
    bin_in[c*BB +: BB] = v;
    m_bin[c] = v;
  endtask

  task automatic wait_all_valid(input string tag);
    for (int n = 0; n < 300 && bcd_valid !== '1; n++) @(negedge clk);
    checks++;
    if (bcd_valid !== '1) begin
      errors++;
      $display("FAIL %s_valid_timeout: bcd_valid=%b, required %b", tag, bcd_valid, {CH{1'b1}});
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (bcd_out[c*RW +: RW] !== to_bcd(m_bin[c])) begin
        errors++;
        $display("FAIL %s_bcd_ch%0d: got %h, required %h", tag, c, bcd_out[c*RW +: RW], to_bcd(m_bin[c]));
      end
    end
  endtask

  // Expected grants are the masked channels visited from last_grant+1 with wrap.
  task automatic expect_starts(input logic [CH-1:0] mask, input string tag);
    int order[$];
    logic [BB-1:0] got;
    for (int i = 1; i <= CH; i++) if (mask[(m_lg + i) % CH]) order.push_back((m_lg + i) % CH);
    for (int n = 0; n < CH * 40 && start_q.size() < order.size(); n++) @(negedge clk);
    checks++;
    if (start_q.size() < order.size()) begin
      errors++;
      $display("FAIL %s_start_count: got %0d, required %0d", tag, start_q.size(), order.size());
    end else begin
      foreach (order[j]) begin
        got = start_q.pop_front();
        checks++;
        if (got !== m_bin[order[j]]) begin
          errors++;
          $display("FAIL %s_grant%0d: cv_bin=%0d, required %0d (ch%0d)", tag, j, got, m_bin[order[j]], order[j]);
        end
      end
      m_lg = order[order.size() - 1];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; force_all = 1'b0; hang = 1'b0; bin_in = '0;
    set_ch(0, 16'd1234); set_ch(1, 16'd0); set_ch(2, 16'd7);
    repeat (3) @(negedge clk);
    checks++;
    if (bcd_out !== '0 || bcd_valid !== '0 || conv_err !== 1'b0 ||
        cv_start !== 1'b0 || cv_bin !== '0) begin
      errors++;
      $display("FAIL reset_state: bcd_out=%h valid=%b err=%b start=%b bin=%h, required all zero",
               bcd_out, bcd_valid, conv_err, cv_start, cv_bin);
    end
    m_lg = CH - 1;
    start_q.delete();
  endtask

  task automatic test_power_up();
    int t0;
    t0 = cyc;
    rst_n = 1'b1;
    expect_starts('1, "power_up");
    wait_all_valid("power_up");
    checks++;
    if (cyc - t0 > 3 * 19 + 2) begin
      errors++;
      $display("FAIL power_up_latency: valid after %0d cycles, required <= %0d", cyc - t0, 3 * 19 + 2);
    end
    check_outputs("power_up");
  endtask

  task automatic test_single_change();
    logic [RW-1:0] old_bcd;
    wait_all_valid("single_pre");
    start_q.delete();
    old_bcd = to_bcd(m_bin[1]);
    set_ch(1, 16'd65535);
    @(negedge clk);
    checks++;
    if (cv_start !== 1'b1 || cv_bin !== 16'd65535 || bcd_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL single_issue: start=%b bin=%0d valid1=%b, required 1/65535/0", cv_start, cv_bin, bcd_valid[1]);
    end
    repeat (17) @(negedge clk);
    checks++;
    if (bcd_out[RW +: RW] !== old_bcd) begin
      errors++;
      $display("FAIL single_early: ch1=%h at t+18, required %h", bcd_out[RW +: RW], old_bcd);
    end
    @(negedge clk);
    checks++;
    if (bcd_out[RW +: RW] !== 20'h65535 || bcd_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL single_capture: ch1=%h valid1=%b at t+19, required 65535/0", bcd_out[RW +: RW], bcd_valid[1]);
    end
    @(negedge clk);
    checks++;
    if (bcd_valid[1] !== 1'b1 || start_q.size() != 1) begin
      errors++;
      $display("FAIL single_valid: valid1=%b starts=%0d, required 1/1", bcd_valid[1], start_q.size());
    end
    start_q.delete();
    m_lg = 1;
  endtask

  task automatic test_rr_order();
    wait_all_valid("rr_pre");
    start_q.delete();
    set_ch(0, 16'd100); set_ch(1, 16'd200); set_ch(2, 16'd300);
    expect_starts('1, "rr_order");
    wait_all_valid("rr_order");
    check_outputs("rr_order");
  endtask

  task automatic test_mid_change();
    bit seen;
    wait_all_valid("mid_pre");
    start_q.delete();
    set_ch(0, 16'd5);
    repeat (9) @(negedge clk);
    set_ch(0, 16'd9);
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (bcd_out[0 +: RW] === 20'h00005) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_first_result: ch0=%h, required 00005", bcd_out[0 +: RW]);
    end
    @(negedge clk);
    checks++;
    if (bcd_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_stale_valid: valid0=%b, required 0", bcd_valid[0]);
    end
    wait_all_valid("mid_change");
    check_outputs("mid_change");
    checks++;
    if (start_q.size() != 2 || start_q[1] !== 16'd9) begin
      errors++;
      $display("FAIL mid_reconvert: starts=%0d, required 2 with second operand 9", start_q.size());
    end
    start_q.delete();
    m_lg = 0;
  endtask

  task automatic test_timeout();
    logic [RW-1:0] old_bcd;
    wait_all_valid("tmo_pre");
    start_q.delete();
    old_bcd = to_bcd(m_bin[2]);
    hang = 1'b1;
    set_ch(2, 16'd4321);
    @(negedge clk);
    checks++;
    if (cv_start !== 1'b1) begin
      errors++;
      $display("FAIL tmo_issue: cv_start=%b, required 1", cv_start);
    end
    repeat (BB + SL - 1) @(negedge clk);
    checks++;
    if (conv_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: conv_err=%b one cycle before limit, required 0", conv_err);
    end
    @(negedge clk);
    checks++;
    if (conv_err !== 1'b1 || bcd_out[2*RW +: RW] !== old_bcd || bcd_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abort: err=%b ch2=%h valid2=%b, required 1/%h/0", conv_err, bcd_out[2*RW +: RW], old_bcd, bcd_valid[2]);
    end
    repeat (30) @(negedge clk);
    hang = 1'b0;
    wait_all_valid("tmo_retry");
    check_outputs("tmo_retry");
    checks++;
    if (conv_err !== 1'b1 || start_q.size() < 2) begin
      errors++;
      $display("FAIL tmo_sticky_retry: err=%b starts=%0d, required 1/>=2", conv_err, start_q.size());
    end
    start_q.delete();
    m_lg = 2;
  endtask

  task automatic test_force_all();
    bit seen;
    wait_all_valid("force_pre");
    start_q.delete();
    force_all = 1'b1;
    @(negedge clk);
    force_all = 1'b0;
    @(negedge clk);
    checks++;
    if (bcd_valid !== '0) begin
      errors++;
      $display("FAIL force_drop: bcd_valid=%b, required 000", bcd_valid);
    end
    seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (bcd_valid[(m_lg + 1) % CH] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || bcd_valid[(m_lg + 3) % CH] !== 1'b0) begin
      errors++;
      $display("FAIL force_per_channel: bcd_valid=%b, first channel back alone required", bcd_valid);
    end
    expect_starts('1, "force_all");
    wait_all_valid("force_all");
    check_outputs("force_all");
  endtask

  task automatic test_random();
    logic [CH-1:0] mask;
    logic [BB-1:0] v;
    bit use_force;
    for (int it = 0; it < 20; it++) begin
      wait_all_valid("rand_pre");
      start_q.delete();
      use_force = ($urandom_range(0, 3) == 0);
      if (use_force) begin
        mask = '1;
        force_all = 1'b1;
        @(negedge clk);
        force_all = 1'b0;
      end else begin
        mask = CH'($urandom_range(1, (1 << CH) - 1));
        for (int c = 0; c < CH; c++) begin
          if (mask[c]) begin
            v = BB'($urandom);
            if (v == m_bin[c]) v = v ^ 16'h1;
            set_ch(c, v);
          end
        end
      end
      expect_starts(mask, "random");
      wait_all_valid("random");
      check_outputs("random");
    end
  endtask

  task automatic test_reset_mid();
    wait_all_valid("rstmid_pre");
    set_ch(1, m_bin[1] ^ 16'h00FF);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bcd_out !== '0 || bcd_valid !== '0 || cv_start !== 1'b0 || conv_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: bcd_out=%h valid=%b start=%b err=%b, required zero",
               bcd_out, bcd_valid, cv_start, conv_err);
    end
    start_q.delete();
    m_lg = CH - 1;
    @(negedge clk);
    rst_n = 1'b1;
    expect_starts('1, "reset_mid");
    wait_all_valid("reset_mid");
    check_outputs("reset_mid");
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_single_change();
    test_rr_order();
    test_mid_change();
    test_timeout();
    test_force_all();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
